// File: rtl/avg_level_monitor.sv
// avg_level_monitor
//   Classifies each (sync, average) result from the step-average stage
//   against signed high/low thresholds. Hysteresis plus DEBOUNCE-sample
//   qualification decides the reported level. Each level change produces a
//   rise/fall event, held in a one-deep buffer behind a valid/ready handshake.
//
// Ports
//   clk        single clock, posedge
//   reset      synchronous, active-low
//   sync       strobe: average is valid this cycle
//   average    signed window average
//   thr_high   signed rise threshold (used on sync cycles only)
//   thr_low    signed fall threshold (used on sync cycles only)
//   level      debounced level, 1 = high
//   evt_valid  event pending
//   evt_ready  consumer accepts the pending event
//   evt_rise   1 = rise event, 0 = fall event
//   evt_value  average that completed the transition
//   overflow   sticky, set when an event is dropped on a full buffer
//   evt_time   sync count at the event (AVG_LEVEL_TIMESTAMP_EN only)
//
// Build option
//   AVG_LEVEL_TIMESTAMP_EN : adds a free-running sync counter and evt_time.
//
// States
//   LOW     | level low, waiting for an average above thr_high
//   RISING  | counting consecutive averages above thr_high
//   HIGH    | level high, waiting for an average below thr_low
//   FALLING | counting consecutive averages below thr_low

module avg_level_monitor #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 3,
  parameter int TS_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sync,
  input  logic signed [WIDTH-1:0] average,
  input  logic signed [WIDTH-1:0] thr_high,
  input  logic signed [WIDTH-1:0] thr_low,
  output logic                    level,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic                    evt_rise,
  output logic signed [WIDTH-1:0] evt_value,
  output logic                    overflow
`ifdef AVG_LEVEL_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]     evt_time
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE);

  if (DEBOUNCE < 1 || TS_WIDTH < 1) begin : g_bad_param
    $error("avg_level_monitor: DEBOUNCE and TS_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {LOW, RISING, HIGH, FALLING} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             above;
  logic             below;
  logic             new_evt;
  logic             new_rise;

  assign above   = average > thr_high;
  assign below   = average < thr_low;
  assign cnt_inc = cnt + CNT_W'(1);

  // An event fires on the sync that completes a transition; with
  // DEBOUNCE==1 that is the first qualifying sample out of LOW/HIGH.
  always_comb begin
    new_evt  = 1'b0;
    new_rise = 1'b0;
    if (sync) begin
      case (state)
        LOW:     if (above && DEBOUNCE == 1) begin
                   new_evt  = 1'b1;
                   new_rise = 1'b1;
                 end
        RISING:  if (above && cnt_inc == DEB_C) begin
                   new_evt  = 1'b1;
                   new_rise = 1'b1;
                 end
        HIGH:    if (below && DEBOUNCE == 1) new_evt = 1'b1;
        FALLING: if (below && cnt_inc == DEB_C) new_evt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef AVG_LEVEL_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOW;
      cnt       <= '0;
      level     <= 1'b0;
      evt_valid <= 1'b0;
      evt_rise  <= 1'b0;
      evt_value <= '0;
      overflow  <= 1'b0;
`ifdef AVG_LEVEL_TIMESTAMP_EN
      ts_cnt    <= '0;
      evt_time  <= '0;
`endif
    end else begin
      if (sync) begin
`ifdef AVG_LEVEL_TIMESTAMP_EN
        ts_cnt <= ts_cnt + TS_WIDTH'(1);
`endif
        case (state)
          LOW: if (above) begin
            if (DEBOUNCE == 1) begin
              state <= HIGH;
              level <= 1'b1;
            end else begin
              state <= RISING;
              cnt   <= CNT_W'(1);
            end
          end
          RISING: if (above) begin
            if (cnt_inc == DEB_C) begin
              state <= HIGH;
              cnt   <= '0;
              level <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            state <= LOW;
            cnt   <= '0;
          end
          HIGH: if (below) begin
            if (DEBOUNCE == 1) begin
              state <= LOW;
              level <= 1'b0;
            end else begin
              state <= FALLING;
              cnt   <= CNT_W'(1);
            end
          end
          FALLING: if (below) begin
            if (cnt_inc == DEB_C) begin
              state <= LOW;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            state <= HIGH;
            cnt   <= '0;
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
            level <= 1'b0;
          end
        endcase
      end

      // One-deep event buffer: a new event loads when the buffer is empty
      // or being drained this cycle; otherwise it is dropped and flagged.
      if (new_evt) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_rise  <= new_rise;
          evt_value <= average;
`ifdef AVG_LEVEL_TIMESTAMP_EN
          evt_time  <= ts_cnt;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
